reg_scoreboard: RTL and testbench

Per-register in-flight write tracker for the 5-stage WISC-SP22 pipeline. It records each destination register when an instruction issues from ID to EX and releases it at writeback. It drives the ID-stage `stall` from its own state, replacing per-stage destination compares. It sits between decode (issue side) and writeback (retire side), with a squash port for the instruction issued in the previous cycle.

---
 rtl/wisc_pkg.sv | 30 +++
 rtl/sb_counter.sv | 86 ++++++++
 rtl/reg_scoreboard.sv | 151 +++++++++++++++
 tb/tb_reg_scoreboard.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// ----------------------------------------------------------------------------
// wisc_pkg
//    Definitions shared by the WISC-SP22 pipeline blocks.
//    - NREGS / REG_W : architectural register count and index width
//    - CNT_W         : default width of the per-register in-flight counter
//    - OPC_NOP       : the NOP opcode, which never stalls
//    - rt_active()   : true when an opcode reads its Rt field. Decode uses the
//                      same function, so the stall logic and the operand
//                      fetch cannot disagree about which instructions use Rt.
// ----------------------------------------------------------------------------
package wisc_pkg;

   localparam int NREGS = 8;
   localparam int REG_W = 3;
   localparam int CNT_W = 2;

   localparam logic [4:0] OPC_NOP = 5'b00001;

   // Rt-reading opcodes are 1101x, 111xx, 10000 and 10011.
   function automatic logic rt_active(input logic [4:0] opcode);
      logic is_1101x;
      logic is_111xx;
      logic is_exact;
      is_1101x = (opcode[4:1] == 4'b1101);
      is_111xx = (opcode[4:2] == 3'b111);
      is_exact = (opcode == 5'b10000) || (opcode == 5'b10011);
      return is_1101x | is_111xx | is_exact;
   endfunction

endpackage

// File: rtl/sb_counter.sv
// ----------------------------------------------------------------------------
// sb_counter
//    One in-flight write counter for a single architectural register.
//    Each cycle the count moves by inc - dec_a - dec_b, a net change of
//    -2..+1.
//
//    Build option SCOREBOARD_CHECK_EN:
//       defined   - an overflow or underflow saturates the count at
//                   max / 0 and pulses err for that cycle
//       undefined - the count wraps modulo 2**CW and there is no err port
//
//    Ports
//       clk, rst_n : clock, asynchronous active-low reset
//       inc        : issue writes this register
//       dec_a      : writeback writes this register
//       dec_b      : squash of last cycle's issue to this register
//       cnt        : current count
//       zero       : count is zero
//       err        : overflow/underflow this cycle (only with the macro)
// ----------------------------------------------------------------------------
module sb_counter #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec_a,
   input  logic          dec_b,
   output logic [CW-1:0] cnt,
   output logic          zero
`ifdef SCOREBOARD_CHECK_EN
   ,
   output logic          err
`endif
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

`ifdef SCOREBOARD_CHECK_EN
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   // Two extra bits hold the result: the top bit is the sign (the result
   // went negative) and the next bit flags a carry past the maximum.
   logic [CW+1:0] sum;
   logic          overflow;
   logic          underflow;

   always_comb begin
      sum       = {2'b00, cnt_q}
                + {{(CW+1){1'b0}}, inc}
                - {{(CW+1){1'b0}}, dec_a}
                - {{(CW+1){1'b0}}, dec_b};
      underflow = sum[CW+1];
      overflow  = sum[CW] & ~sum[CW+1];
      err       = overflow | underflow;
      if (underflow) begin
         cnt_d = '0;
      end else if (overflow) begin
         cnt_d = CNT_MAX;
      end else begin
         cnt_d = sum[CW-1:0];
      end
   end
`else
   // Without checking, the count simply wraps.
   always_comb begin
      cnt_d = cnt_q
            + {{(CW-1){1'b0}}, inc}
            - {{(CW-1){1'b0}}, dec_a}
            - {{(CW-1){1'b0}}, dec_b};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
//    Per-register in-flight write tracker for the 5-stage WISC-SP22
//    pipeline. The block records the destination of every register-writing
//    instruction that issues from ID to EX and releases it at writeback.
//    The ID-stage stall comes from this state rather than from comparing
//    destinations stage by stage.
//
//    Build option SCOREBOARD_CHECK_EN:
//       defined   - a counter overflow/underflow sets sticky sb_err and the
//                   counter saturates
//       undefined - sb_err is tied 0 and the counters wrap
//
//    Ports
//       clk, rst_n              : clock, asynchronous active-low reset
//       issue_valid/_wr/_dst    : instruction moving ID->EX and its destination
//       retire_valid/_dst       : register write in WB this cycle
//       squash                  : cancel the instruction issued last cycle
//       OpCode_ID, Rs_ID, Rt_ID : operands of the instruction now in ID
//       stall                   : hold IF/ID this cycle
//       busy                    : per-register write-pending vector
//       idle                    : no writes in flight
//       sb_err                  : sticky protocol error
// ----------------------------------------------------------------------------
module reg_scoreboard
   import wisc_pkg::*;
#(
   parameter int NREGS = wisc_pkg::NREGS,
   parameter int CW    = wisc_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic             issue_wr,
   input  logic [2:0]       issue_dst,
   input  logic             retire_valid,
   input  logic [2:0]       retire_dst,
   input  logic             squash,
   input  logic [4:0]       OpCode_ID,
   input  logic [2:0]       Rs_ID,
   input  logic [2:0]       Rt_ID,
   output logic             stall,
   output logic [NREGS-1:0] busy,
   output logic             idle,
   output logic             sb_err
);

   // Record of last cycle's issue, used only to route a squash back to the
   // counter that issue incremented.
   logic       last_vld_q;
   logic       last_vld_d;
   logic [2:0] last_dst_q;
   logic [2:0] last_dst_d;

   logic [NREGS-1:0] inc;
   logic [NREGS-1:0] dec_retire;
   logic [NREGS-1:0] dec_squash;
   logic [NREGS-1:0] zero;
   logic [CW-1:0]    cnt [NREGS];

`ifdef SCOREBOARD_CHECK_EN
   logic [NREGS-1:0] cnt_err;
`endif

   // Decode the issue, retire and squash events into per-register strobes.
   always_comb begin
      inc        = '0;
      dec_retire = '0;
      dec_squash = '0;
      for (int r = 0; r < NREGS; r++) begin
         inc[r]        = issue_valid & issue_wr & (int'(issue_dst) == r);
         dec_retire[r] = retire_valid & (int'(retire_dst) == r);
         dec_squash[r] = squash & last_vld_q & (int'(last_dst_q) == r);
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_cnt
      sb_counter #(
         .CW    (CW)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc[g]),
         .dec_a (dec_retire[g]),
         .dec_b (dec_squash[g]),
         .cnt   (cnt[g]),
         .zero  (zero[g])
`ifdef SCOREBOARD_CHECK_EN
         ,
         .err   (cnt_err[g])
`endif
      );
   end

   // The register file writes before it reads, so a register whose last
   // pending write retires this cycle is already readable.
   always_comb begin
      busy = '0;
      for (int r = 0; r < NREGS; r++) begin
         busy[r] = ~zero[r]
                 & ~((cnt[r] == {{(CW-1){1'b0}}, 1'b1}) & dec_retire[r]);
      end
   end

   // Stall on a pending Rs, or on a pending Rt when the opcode reads Rt.
   // A NOP reads nothing and never stalls.
   always_comb begin
      stall = (busy[Rs_ID] | (rt_active(OpCode_ID) & busy[Rt_ID]))
            & (OpCode_ID != OPC_NOP);
      idle  = &zero;
   end

   // Issue record next state: a non-writing issue leaves nothing to squash.
   always_comb begin
      last_vld_d = issue_valid & issue_wr;
      last_dst_d = issue_dst;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_vld_q <= 1'b0;
         last_dst_q <= '0;
      end else begin
         last_vld_q <= last_vld_d;
         last_dst_q <= last_dst_d;
      end
   end

`ifdef SCOREBOARD_CHECK_EN
   logic sb_err_q;
   logic sb_err_d;

   // Sticky error: any counter fault latches until reset.
   always_comb begin
      sb_err_d = sb_err_q | (|cnt_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_err_q <= 1'b0;
      end else begin
         sb_err_q <= sb_err_d;
      end
   end

   assign sb_err = sb_err_q;
`else
   assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_reg_scoreboard
//    Self-checking bench for reg_scoreboard. A reference model keeps a plain
//    integer count of pending writes per register and derives busy/stall/idle
//    from it. Directed scenarios come first, then random traffic, then an
//    asynchronous reset in the middle of a run.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       issue_valid;
   logic       issue_wr;
   logic [2:0] issue_dst;
   logic       retire_valid;
   logic [2:0] retire_dst;
   logic       squash;
   logic [4:0] OpCode_ID;
   logic [2:0] Rs_ID;
   logic [2:0] Rt_ID;
   logic       stall;
   logic [7:0] busy;
   logic       idle;
   logic       sb_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_cnt [8];
   bit m_last_vld;
   int m_last_dst;
   bit m_err;

   reg_scoreboard dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_wr     (issue_wr),
      .issue_dst    (issue_dst),
      .retire_valid (retire_valid),
      .retire_dst   (retire_dst),
      .squash       (squash),
      .OpCode_ID    (OpCode_ID),
      .Rs_ID        (Rs_ID),
      .Rt_ID        (Rt_ID),
      .stall        (stall),
      .busy         (busy),
      .idle         (idle),
      .sb_err       (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit modelRtActive(input int op);
      // 1101x = 26,27 ; 111xx = 28..31 ; 10000 = 16 ; 10011 = 19
      return (op == 26) || (op == 27) || (op >= 28) || (op == 16) || (op == 19);
   endfunction

   function automatic bit modelBusy(input int r);
      if (m_cnt[r] == 0) return 1'b0;
      if (m_cnt[r] == 1 && retire_valid && int'(retire_dst) == r) return 1'b0;
      return 1'b1;
   endfunction

   task automatic modelReset();
      for (int r = 0; r < 8; r++) m_cnt[r] = 0;
      m_last_vld = 0;
      m_last_dst = 0;
      m_err      = 0;
   endtask

   // Advance the model by one clock using the inputs driven this cycle.
   task automatic modelUpdate();
      for (int r = 0; r < 8; r++) begin
         int nxt;
         nxt = m_cnt[r];
         if (issue_valid && issue_wr && int'(issue_dst) == r) nxt = nxt + 1;
         if (retire_valid && int'(retire_dst) == r) nxt = nxt - 1;
         if (squash && m_last_vld && m_last_dst == r) nxt = nxt - 1;
`ifdef SCOREBOARD_CHECK_EN
         if (nxt > 3) begin nxt = 3; m_err = 1; end
         if (nxt < 0) begin nxt = 0; m_err = 1; end
`else
         nxt = (nxt + 4) % 4;
`endif
         m_cnt[r] = nxt;
      end
      m_last_vld = issue_valid && issue_wr;
      m_last_dst = int'(issue_dst);
   endtask

   task automatic checkCycle(input string tag);
      logic [7:0] exp_busy;
      bit         exp_idle;
      bit         exp_stall;
      exp_idle = 1;
      for (int r = 0; r < 8; r++) begin
         exp_busy[r] = modelBusy(r);
         if (m_cnt[r] != 0) exp_idle = 0;
      end
      exp_stall = (exp_busy[Rs_ID] || (modelRtActive(int'(OpCode_ID)) && exp_busy[Rt_ID]))
                  && (OpCode_ID != 5'd1);
      checkOutput({tag, ".busy"},  32'(busy),   32'(exp_busy));
      checkOutput({tag, ".stall"}, 32'(stall),  32'(exp_stall));
      checkOutput({tag, ".idle"},  32'(idle),   32'(exp_idle));
      checkOutput({tag, ".err"},   32'(sb_err), 32'(m_err));
   endtask

   // Drive one cycle's inputs after the falling edge and check the
   // combinational outputs against the model before the rising edge.
   task automatic applyStimulus(input string tag,
                                input bit iv, input bit iw, input int idst,
                                input bit rv, input int rdst, input bit sq,
                                input int op, input int rs, input int rt);
      @(negedge clk);
      issue_valid  = iv;
      issue_wr     = iw;
      issue_dst    = 3'(idst);
      retire_valid = rv;
      retire_dst   = 3'(rdst);
      squash       = sq;
      OpCode_ID    = 5'(op);
      Rs_ID        = 3'(rs);
      Rt_ID        = 3'(rt);
      #1;
      checkCycle(tag);
   endtask

   task automatic finishCycle();
      @(posedge clk);
      modelUpdate();
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(tag, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      finishCycle();
   endtask

   task automatic issueCycle(input string tag, input int dst);
      applyStimulus(tag, 1, 1, dst, 0, 0, 0, 1, 0, 0);
      finishCycle();
   endtask

   task automatic retireCycle(input string tag, input int dst);
      applyStimulus(tag, 0, 0, 0, 1, dst, 0, 1, 0, 0);
      finishCycle();
   endtask

   task automatic randomCycle(input string tag);
      applyStimulus(tag, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                    1'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
      finishCycle();
   endtask

   initial begin
      rst_n        = 1'b0;
      issue_valid  = 1'b0;
      issue_wr     = 1'b0;
      issue_dst    = '0;
      retire_valid = 1'b0;
      retire_dst   = '0;
      squash       = 1'b0;
      OpCode_ID    = 5'd1;
      Rs_ID        = '0;
      Rt_ID        = '0;
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      applyStimulus("reset", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("reset.busy0",  32'(busy),   32'h00);
      checkOutput("reset.idle1",  32'(idle),   32'h1);
      checkOutput("reset.stall0", 32'(stall),  32'h0);
      checkOutput("reset.err0",   32'(sb_err), 32'h0);
      finishCycle();

      // ADD writing R3, then ADDI reading R3, then R3 retires
      applyStimulus("add_r3", 1, 1, 3, 0, 0, 0, 5'b11011, 0, 0);
      finishCycle();
      applyStimulus("addi_rs3", 0, 0, 0, 0, 0, 0, 5'b01000, 3, 0);
      checkOutput("busy_r3",  32'(busy),  32'h08);
      checkOutput("stall_r3", 32'(stall), 32'h1);
      finishCycle();
      applyStimulus("retire_r3", 0, 0, 0, 1, 3, 0, 5'b01000, 3, 0);
      checkOutput("retire_r3_nostall", 32'(stall), 32'h0);
      finishCycle();

      // Three outstanding writes to R2, then a fourth
      for (int i = 0; i < 3; i++) issueCycle("r2_fill", 2);
      applyStimulus("r2_over", 1, 1, 2, 0, 0, 0, 1, 0, 0);
      finishCycle();
      applyStimulus("r2_after", 0, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef SCOREBOARD_CHECK_EN
      checkOutput("r2_sat_err",  32'(sb_err),  32'h1);
      checkOutput("r2_sat_busy", 32'(busy[2]), 32'h1);
      finishCycle();
      for (int i = 0; i < 3; i++) retireCycle("r2_drain", 2);
`else
      checkOutput("r2_wrap_busy", 32'(busy[2]), 32'h0);
      checkOutput("r2_wrap_idle", 32'(idle),    32'h1);
      finishCycle();
`endif

      // Issue and retire R5 in the same cycle while one write is pending
      issueCycle("r5_issue", 5);
      applyStimulus("r5_both", 1, 1, 5, 1, 5, 0, 1, 0, 0);
      checkOutput("r5_both_bypass", 32'(busy[5]), 32'h0);
      finishCycle();
      applyStimulus("r5_hold", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("r5_still_busy", 32'(busy[5]), 32'h1);
      finishCycle();
      retireCycle("r5_retire", 5);

      // Squash the R4 issue in the following cycle
      issueCycle("r4_issue", 4);
      applyStimulus("r4_squash", 0, 0, 0, 0, 0, 1, 1, 0, 0);
      checkOutput("r4_busy_before", 32'(busy[4]), 32'h1);
      finishCycle();
      applyStimulus("r4_gone", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("r4_busy_after", 32'(busy[4]), 32'h0);
      checkOutput("r4_idle_after", 32'(idle),    32'h1);
      finishCycle();
      applyStimulus("lone_squash", 0, 0, 0, 0, 0, 1, 1, 0, 0);
      finishCycle();
      applyStimulus("lone_squash_after", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("lone_squash_idle", 32'(idle), 32'h1);
      finishCycle();

      // Opcode-dependent stall gating
      issueCycle("r1_issue", 1);
      applyStimulus("nop_rs1", 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0);
      checkOutput("nop_no_stall", 32'(stall), 32'h0);
      finishCycle();
      issueCycle("r6_issue", 6);
      applyStimulus("op10110_rt6", 0, 0, 0, 0, 0, 0, 5'b10110, 0, 6);
      checkOutput("rt_ignored", 32'(stall), 32'h0);
      finishCycle();
      applyStimulus("op11011_rt6", 0, 0, 0, 0, 0, 0, 5'b11011, 0, 6);
      checkOutput("rt_used", 32'(stall), 32'h1);
      finishCycle();
      retireCycle("r1_retire", 1);
      retireCycle("r6_retire", 6);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) randomCycle("rand");

      // Asynchronous reset in the middle of a run
      issueCycle("pre_rst0", 0);
      issueCycle("pre_rst1", 1);
      issueCycle("pre_rst7", 7);
      @(negedge clk);
      issue_valid  = 1'b0;
      retire_valid = 1'b0;
      squash       = 1'b0;
      OpCode_ID    = 5'b01000;
      Rs_ID        = 3'd7;
      Rt_ID        = 3'd0;
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("midrst.busy",  32'(busy),   32'h00);
      checkOutput("midrst.stall", 32'(stall),  32'h0);
      checkOutput("midrst.idle",  32'(idle),   32'h1);
      checkOutput("midrst.err",   32'(sb_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) randomCycle("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
